// File: rtl/multi_shifter.sv
// rtl/multi_shifter.sv - multi-cycle 16-bit shift sequencer, one bit per clock
module multi_shifter (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] in,
    input  logic [1:0]  shift,
    input  logic [3:0]  amount,
    output logic [15:0] sout,
    output logic        carry,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [1:0]  op;
    logic [3:0]  cnt;
    logic        accept;

    assign accept = start && ((state == IDLE) || (state == DONE));
    assign busy   = (state == SHIFT);
    assign done   = (state == DONE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next = ((amount == 4'd0) || (shift == 2'b00)) ? DONE : SHIFT;
                end else begin
                    state_next = IDLE;
                end
            end
            SHIFT: begin
                // cnt is never 0 here; <= keeps a corrupted count from wrapping forever
                if (cnt <= 4'd1) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            sout  <= 16'h0000;
            carry <= 1'b0;
            op    <= 2'b00;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            if (accept) begin
                sout  <= in;
                carry <= 1'b0;
                op    <= shift;
                cnt   <= amount;
            end else if (state == SHIFT) begin
                case (op)
                    2'b01: begin
                        carry <= sout[15];
                        sout  <= {sout[14:0], 1'b0};
                    end
                    2'b10: begin
                        carry <= sout[0];
                        sout  <= {1'b0, sout[15:1]};
                    end
                    2'b11: begin
                        carry <= sout[0];
                        sout  <= {sout[15], sout[15:1]};
                    end
                    default: begin
                        carry <= carry;
                        sout  <= sout;
                    end
                endcase
                cnt <= cnt - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_multi_shifter.sv
// tb/tb_multi_shifter.sv - randomized and directed bench for multi_shifter against a closed-form model
module tb_multi_shifter;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] d_in;
    logic [1:0]  d_shift;
    logic [3:0]  d_amount;
    logic [15:0] sout;
    logic        carry;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    logic [15:0] trace [0:40];
    logic        tbusy [0:40];

    // model: k = cycle number since the accepted start (-1 when idle)
    bit          m_valid = 1'b0;
    int          m_k = -1;
    int          m_n = 0;
    logic [15:0] m_in = 16'h0;
    logic [1:0]  m_op = 2'b00;
    logic [15:0] m_sout = 16'h0;
    logic        m_carry = 1'b0;

    multi_shifter dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .in     (d_in),
        .shift  (d_shift),
        .amount (d_amount),
        .sout   (sout),
        .carry  (carry),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    // result of s whole steps applied at once: {carry, value}
    function automatic logic [16:0] ref_op(input logic [15:0] v, input logic [1:0] op, input int s);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b0;
        if (s > 0) begin
            case (op)
                2'b01: begin r = v << s; c = v[16 - s]; end
                2'b10: begin r = v >> s; c = v[s - 1]; end
                2'b11: begin r = $unsigned($signed(v) >>> s); c = v[s - 1]; end
                default: begin r = v; c = 1'b0; end
            endcase
        end
        return {c, r};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        logic [16:0] r;
        if (reset) begin
            m_valid = 1'b1;
            m_k     = -1;
            m_sout  = 16'h0;
            m_carry = 1'b0;
        end else if (m_valid) begin
            if ((m_k < 0 || m_k == m_n + 1) && start) begin
                m_in = d_in;
                m_op = d_shift;
                m_n  = (d_shift == 2'b00) ? 0 : int'(d_amount);
                m_k  = 1;
            end else if (m_k >= 1 && m_k <= m_n) begin
                m_k++;
            end else if (m_k == m_n + 1) begin
                m_k = -1;
            end
            if (m_k >= 1) begin
                r = ref_op(m_in, m_op, (m_k - 1 < m_n) ? m_k - 1 : m_n);
                m_sout  = r[15:0];
                m_carry = r[16];
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid && !reset) begin
            check("sout",  32'(sout),  32'(m_sout));
            check("carry", 32'(carry), 32'(m_carry));
            check("busy",  32'(busy),  32'(m_k >= 1 && m_k <= m_n));
            check("done",  32'(done),  32'(m_k >= 1 && m_k == m_n + 1));
        end
    end

    task automatic launch(input logic [15:0] v, input logic [1:0] sh, input logic [3:0] am);
        @(posedge clk); #2;
        start = 1'b1; d_in = v; d_shift = sh; d_amount = am;
        @(posedge clk); #2;
        start = 1'b0; d_in = 16'($urandom); d_shift = 2'($urandom); d_amount = 4'($urandom);
    endtask

    // entered at posedge+2 of cycle 1; returns at the negedge of the done cycle
    task automatic run_to_done(input int poke, output int dc);
        dc = -1;
        for (int c = 1; c <= 40; c++) begin
            if (c == poke) begin
                start = 1'b1; d_in = 16'hAAAA;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            trace[c] = sout;
            tbusy[c] = busy;
            if (done) begin
                dc = c;
                break;
            end
            @(posedge clk); #2;
        end
        if (dc < 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done within 40 cycles expected done");
        end
    endtask

    initial begin
        int dc;
        reset = 1'b1; start = 1'b0; d_in = 16'h0; d_shift = 2'b00; d_amount = 4'd0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("idle_sout", 32'(sout), 32'h0);
            check("idle_flags", {carry, busy, done}, 32'h0);
        end

        launch(16'h8001, 2'b01, 4'd1);
        run_to_done(0, dc);
        check("lsl1_done_cycle", 32'(dc), 32'd2);
        check("lsl1_busy_c1", 32'(tbusy[1]), 32'd1);
        check("lsl1_sout", 32'(sout), 32'h0002);
        check("lsl1_carry", 32'(carry), 32'd1);

        launch(16'h8000, 2'b11, 4'd4);
        run_to_done(0, dc);
        check("asr4_done_cycle", 32'(dc), 32'd5);
        check("asr4_c2", 32'(trace[2]), 32'hC000);
        check("asr4_c3", 32'(trace[3]), 32'hE000);
        check("asr4_c4", 32'(trace[4]), 32'hF000);
        check("asr4_sout", 32'(sout), 32'hF800);
        check("asr4_carry", 32'(carry), 32'd0);

        launch(16'hFFFF, 2'b10, 4'd15);
        run_to_done(0, dc);
        check("lsr15_done_cycle", 32'(dc), 32'd16);
        check("lsr15_sout", 32'(sout), 32'h0001);
        check("lsr15_carry", 32'(carry), 32'd1);
        start = 1'b1; d_in = 16'h1234; d_shift = 2'b00; d_amount = 4'd7;
        @(posedge clk); #2;
        start = 1'b0;
        run_to_done(0, dc);
        check("b2b_done_cycle", 32'(dc), 32'd1);
        check("b2b_sout", 32'(sout), 32'h1234);
        check("b2b_carry", 32'(carry), 32'd0);

        launch(16'h00FF, 2'b01, 4'd8);
        run_to_done(3, dc);
        check("ign_done_cycle", 32'(dc), 32'd9);
        check("ign_sout", 32'(sout), 32'hFF00);
        check("ign_carry", 32'(carry), 32'd0);

        launch(16'h0F0F, 2'b10, 4'd6);
        @(posedge clk); #2;
        reset = 1'b1;
        @(posedge clk); #2;
        reset = 1'b0;
        @(negedge clk);
        check("rst_sout", 32'(sout), 32'h0);
        check("rst_flags", {carry, busy, done}, 32'h0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("rst_no_done", 32'(done), 32'd0);
        end

        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #2;
            reset    = ($urandom_range(0, 99) == 0);
            start    = ($urandom_range(0, 2) == 0);
            d_in     = 16'($urandom);
            d_shift  = 2'($urandom);
            d_amount = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 1) * 15) : 4'($urandom);
        end
        @(posedge clk); #2;
        reset = 1'b0; start = 1'b0;
        repeat (20) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
